// File: rtl/credit_rx_buffer.sv
// credit_rx_buffer: receive-side terminator of a valid/credit link.
// Buffers upstream beats in a DEPTH-entry FIFO, presents them downstream
// as valid/ready, and returns one credit per freed slot. The initial
// DEPTH credits are released after reset.
module credit_rx_buffer #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_credit,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [CNT_W-1:0]  credit_pending,
  output logic              overflow_err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_pending;
  logic              r_credit;
  logic              r_ovf;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_overflow;
  logic              w_owe;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_pending_nxt;

  // Handshake decode, pointer wrap and counter next-state.
  always_comb begin
    w_full        = (r_count == CNT_W'(DEPTH));
    w_pop         = (r_count != '0) && out_ready;
    w_push        = in_valid && (!w_full || w_pop);
    w_overflow    = in_valid && w_full && !w_pop;
    w_owe         = (r_pending != '0);
    w_wr_ptr_nxt  = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    w_rd_ptr_nxt  = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
    w_count_nxt   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_pending_nxt = r_pending + CNT_W'(w_pop) - CNT_W'(w_owe);
  end

  // Control state: pointers, occupancy, credits owed and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= CNT_W'(DEPTH);
      r_credit  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pending_nxt;
      r_credit  <= w_owe;
      if (w_overflow) r_ovf <= 1'b1;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // Simulation checks: dropped beat and credit bookkeeping bound.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!w_overflow)
        else $warning("credit_rx_buffer: beat dropped while buffer full");
      assert (r_pending <= CNT_W'(DEPTH))
        else $error("credit_rx_buffer: credit_pending exceeds DEPTH");
    end
  end

  // Head of FIFO is visible straight from the storage registers.
  always_comb begin
    out_valid      = (r_count != '0);
    out_data       = r_mem[r_rd_ptr];
    fifo_count     = r_count;
    credit_pending = r_pending;
    in_credit      = r_credit;
    overflow_err   = r_ovf;
  end

endmodule

// File: tb/tb_credit_rx_buffer.sv
// Directed bench for credit_rx_buffer: vector table on a DEPTH=4 instance,
// hand sequences for mid-run reset and DEPTH=3 pointer wrap.
module tb_credit_rx_buffer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic        reset, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_credit, out_valid, overflow_err;
  logic [31:0] out_data;
  logic [2:0]  fifo_count, credit_pending;

  credit_rx_buffer #(.DATA_W(32), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_credit(in_credit), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .fifo_count(fifo_count),
    .credit_pending(credit_pending), .overflow_err(overflow_err)
  );

  // DEPTH=3 instance
  logic        reset3, in_valid3, out_ready3;
  logic [31:0] in_data3;
  logic        in_credit3, out_valid3, overflow_err3;
  logic [31:0] out_data3;
  logic [1:0]  fifo_count3, credit_pending3;

  credit_rx_buffer #(.DATA_W(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset3), .in_valid(in_valid3), .in_data(in_data3),
    .in_credit(in_credit3), .out_valid(out_valid3), .out_data(out_data3),
    .out_ready(out_ready3), .fifo_count(fifo_count3),
    .credit_pending(credit_pending3), .overflow_err(overflow_err3)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    int          ecnt;
    int          epend;
    logic        ecred;
    logic        eovf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic rdy,
                              input logic ev, input logic [31:0] ed, input int ecnt,
                              input int epend, input logic ecred, input logic eovf);
    vec_t v;
    v.iv = iv; v.d = d; v.rdy = rdy; v.ev = ev; v.ed = ed;
    v.ecnt = ecnt; v.epend = epend; v.ecred = ecred; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int credits3, pops3, exp_idx;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    reset3 = 1'b1; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;

    // Rows: inputs for the cycle, then outputs expected during that cycle.
    vecs[0]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 4, 0, 0);
    vecs[1]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 3, 1, 0);
    vecs[2]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 2, 1, 0);
    vecs[3]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 1, 0);
    vecs[4]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0);
    vecs[5]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0);
    vecs[6]  = mk(1, 32'hA5A5_0001, 1, 0, 32'h0,         0, 0, 0, 0);
    vecs[7]  = mk(0, 32'h0,         1, 1, 32'hA5A5_0001, 1, 0, 0, 0);
    vecs[8]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 0, 0);
    vecs[9]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0);
    vecs[10] = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0);
    vecs[11] = mk(1, 32'h10,        0, 0, 32'h0,         0, 0, 0, 0);
    vecs[12] = mk(1, 32'h11,        0, 1, 32'h10,        1, 0, 0, 0);
    vecs[13] = mk(1, 32'h12,        0, 1, 32'h10,        2, 0, 0, 0);
    vecs[14] = mk(1, 32'h13,        0, 1, 32'h10,        3, 0, 0, 0);
    vecs[15] = mk(1, 32'h20,        1, 1, 32'h10,        4, 0, 0, 0);
    vecs[16] = mk(1, 32'h14,        0, 1, 32'h11,        4, 1, 0, 0);
    vecs[17] = mk(0, 32'h0,         1, 1, 32'h11,        4, 0, 1, 1);
    vecs[18] = mk(0, 32'h0,         1, 1, 32'h12,        3, 1, 0, 1);
    vecs[19] = mk(0, 32'h0,         1, 1, 32'h13,        2, 1, 1, 1);
    vecs[20] = mk(0, 32'h0,         1, 1, 32'h20,        1, 1, 1, 1);
    vecs[21] = mk(0, 32'h0,         1, 0, 32'h0,         0, 1, 1, 1);
    vecs[22] = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 1);
    vecs[23] = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 1);

    tick();
    tick();
    reset = 1'b0;

    // Table-driven run on the DEPTH=4 instance.
    for (int i = 0; i < NV; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].rdy;
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) chk("out_data", i, out_data, vecs[i].ed);
      chk("fifo_count", i, 32'(fifo_count), vecs[i].ecnt);
      chk("credit_pending", i, 32'(credit_pending), vecs[i].epend);
      chk("in_credit", i, 32'(in_credit), 32'(vecs[i].ecred));
      chk("overflow_err", i, 32'(overflow_err), 32'(vecs[i].eovf));
      tick();
    end

    // Mid-run reset: fill 4, pop one to reach count=3 / pending=1.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h30 + 32'(i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_reset_count", 0, 32'(fifo_count), 32'd3);
    chk("pre_reset_pending", 0, 32'(credit_pending), 32'd1);
    reset = 1'b1;
    tick();
    chk("rst_count", 0, 32'(fifo_count), 32'd0);
    chk("rst_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_ovf", 0, 32'(overflow_err), 32'd0);
    chk("rst_pending", 0, 32'(credit_pending), 32'd4);
    chk("rst_credit", 0, 32'(in_credit), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("reinit_credit", i, 32'(in_credit), (i <= 4) ? 32'd1 : 32'd0);
      chk("reinit_pending", i, 32'(credit_pending), (i <= 4) ? 32'(4 - i) : 32'd0);
    end

    // DEPTH=3: streaming push/pop across pointer wrap.
    credits3 = 0; pops3 = 0; exp_idx = 0;
    reset3 = 1'b1;
    tick();
    reset3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      credits3 += 32'(in_credit3);
    end
    chk("d3_init_credits", 0, credits3, 32'd3);
    for (int c = 0; c < 12; c++) begin
      in_valid3  = (c < 10);
      in_data3   = 32'(c);
      out_ready3 = 1'b1;
      #1;
      if (out_valid3) begin
        chk("d3_order", exp_idx, out_data3, 32'(exp_idx));
        exp_idx++;
        pops3++;
      end
      tick();
      credits3 += 32'(in_credit3);
    end
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      credits3 += 32'(in_credit3);
    end
    chk("d3_pops", 0, pops3, 32'd10);
    chk("d3_total_credits", 0, credits3, 32'd13);
    chk("d3_count", 0, 32'(fifo_count3), 32'd0);
    chk("d3_ovf", 0, 32'(overflow_err3), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
